// File: rtl/flog_pkg.sv
// flog_pkg -- shared constants and types for the philo log2 arbiter slice.
//   FRACT_WIDTH_PHILO : mantissa width (1.M, MSB is the implicit one)
//   OUT_WIDTH_PHILO   : fractional log2 result width
//   N_IT_PHILO        : core iterations, one result bit per iteration
//   NUM_REQ_PHILO     : default requester count sharing one core
//   PHILO_TIMEOUT     : max cycles from core launch to core valid
//   ss_arb_t          : arbiter FSM states
package flog_pkg;

  localparam int FRACT_WIDTH_PHILO = 16;
  localparam int OUT_WIDTH_PHILO   = 8;
  localparam int N_IT_PHILO        = OUT_WIDTH_PHILO;
  localparam int NUM_REQ_PHILO     = 4;
  localparam int PHILO_TIMEOUT     = OUT_WIDTH_PHILO + 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } ss_arb_t;

endpackage

// File: rtl/philo_arb_core.sv
// philo_arb_core -- iterative fractional log2 by repeated squaring.
// x = man / 2^(FW-1) lies in [1,2). Squaring doubles log2(x); if x^2 >= 2
// the next result bit is 1 and x^2 is halved back into [1,2). One bit per
// cycle, MSB first. The product is truncated to FW bits each step.
//   clk       : clock
//   rst       : synchronous active-high reset (arbiter reset OR flush)
//   in_valid  : start pulse, ignored while busy
//   man       : mantissa 1.M, MSB = 1
//   out_valid : one-cycle pulse, N_IT_PHILO+1 cycles after in_valid
//   result    : fractional log2 bits 0.b(n-1)..b0
module philo_arb_core
  import flog_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [FRACT_WIDTH_PHILO-1:0] man,
  output logic                         out_valid,
  output logic [OUT_WIDTH_PHILO-1:0]   result
);

  localparam int FW = FRACT_WIDTH_PHILO;
  localparam int CW = $clog2(N_IT_PHILO);

  logic [FW-1:0]   x;
  logic [2*FW-1:0] sq;
  logic [FW-1:0]   x_next;
  logic            bit_next;
  logic            busy;
  logic [CW-1:0]   it_cnt;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    sq       = {{FW{1'b0}}, x} * {{FW{1'b0}}, x};
    bit_next = sq[2*FW-1];
    // Renormalise into [1,2): drop one extra bit when the square reached 2.
    x_next   = bit_next ? sq[2*FW-1 -: FW] : sq[2*FW-2 -: FW];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      busy      <= 1'b0;
      it_cnt    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (busy) begin
        x      <= x_next;
        result <= {result[OUT_WIDTH_PHILO-2:0], bit_next};
        it_cnt <= it_cnt + CW'(1);
        if (it_cnt == CW'(N_IT_PHILO - 1)) begin
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
      end else if (in_valid) begin
        x      <= man;
        result <= '0;
        it_cnt <= '0;
        busy   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/philo_arb.sv
// philo_arb -- round-robin arbiter sharing one iterative log2 core among
// NUM_REQ requesters, one request in flight, with a core watchdog.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid_i  : per-requester request, held until its req_ready_o
//   req_man_i    : per-requester mantissa 1.M
//   req_ready_o  : one-hot accept, combinational, IDLE only
//   rsp_valid_o  : response valid (RESP state)
//   rsp_ready_i  : response consumer ready
//   rsp_id_o     : index of the served requester
//   rsp_data_o   : fractional log2 result (0 on timeout)
//   rsp_err_o    : response is a timeout
module philo_arb
  import flog_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_PHILO,
  parameter int TIMEOUT = PHILO_TIMEOUT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid_i,
  input  logic [NUM_REQ-1:0][FRACT_WIDTH_PHILO-1:0] req_man_i,
  output logic [NUM_REQ-1:0]                        req_ready_o,
  output logic                                      rsp_valid_o,
  input  logic                                      rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]                rsp_id_o,
  output logic [OUT_WIDTH_PHILO-1:0]                rsp_data_o,
  output logic                                      rsp_err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  ss_arb_t                      state, state_next;
  logic [IW-1:0]                rr_ptr, cur_id, gnt_idx, cand;
  logic                         gnt_any;
  logic [FRACT_WIDTH_PHILO-1:0] cur_man;
  logic [TW-1:0]                tmo_cnt;
  logic                         tmo_hit;
  logic                         core_in_valid, core_valid, core_flush, core_rst;
  logic [OUT_WIDTH_PHILO-1:0]   core_result;

  // First valid requester at or after rr_ptr, with wrap-around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_any && req_valid_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Core valid wins over the watchdog on the same cycle.
  assign tmo_hit  = (state == WAIT) && !core_valid && (tmo_cnt == TW'(TIMEOUT));
  assign core_rst = rst | core_flush;
  assign rsp_id_o = cur_id;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (gnt_any) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (core_valid || tmo_hit) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = '0;
    rsp_valid_o   = 1'b0;
    core_in_valid = 1'b0;
    core_flush    = 1'b0;
    unique case (state)
      IDLE:    if (gnt_any && !rst) req_ready_o[gnt_idx] = 1'b1;
      LAUNCH:  core_in_valid = 1'b1;
      WAIT:    core_flush = tmo_hit;
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cur_id     <= '0;
      cur_man    <= '0;
      tmo_cnt    <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (gnt_any) begin
          cur_id  <= gnt_idx;
          cur_man <= req_man_i[gnt_idx];
        end
        LAUNCH: tmo_cnt <= '0;
        WAIT: begin
          if (core_valid) begin
            rsp_data_o <= core_result;
            rsp_err_o  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: if (rsp_ready_i) begin
          rr_ptr <= (cur_id == IW'(NUM_REQ - 1)) ? '0 : cur_id + IW'(1);
        end
        default: ;
      endcase
    end
  end

  philo_arb_core u_core (
    .clk       (clk),
    .rst       (core_rst),
    .in_valid  (core_in_valid),
    .man       (cur_man),
    .out_valid (core_valid),
    .result    (core_result)
  );

endmodule
